// File: rtl/elevator_fsm_core.sv
// Elevator controller core: SCAN scheduling with timed per-floor travel and door dwell.
// Consumes request/control strobes from the register file; all outputs are registered.
module elevator_fsm_core #(
  parameter int unsigned NUM_FLOORS    = 4,
  parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  req_wr,
  input  logic [NUM_FLOORS-1:0] req_mask,
  input  logic                  clr_pending,
  input  logic                  hold,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  arrive,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StMoveUp   = 2'd1,
    StMoveDown = 2'd2,
    StDoorOpen = 2'd3
  } state_e;

  localparam logic [FLOOR_W-1:0] TopFloor   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [CNT_W-1:0]   TravelLoad = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DoorLoad   = CNT_W'(DOOR_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      cur_floor_q, cur_floor_d, next_floor;
  logic                    dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    arrive_q, arrive_d;
  logic                    moving_q, door_open_q;
  logic [CNT_W-1:0]        timer_q, timer_d;
  logic [NUM_FLOORS-1:0]   incoming, eff, served;

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] m,
                                     input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (m[i] && (FLOOR_W'(i) > f)) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] m,
                                     input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (m[i] && (FLOOR_W'(i) < f)) r = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    // clr_pending discards everything, including a request written in the same cycle
    incoming    = (req_wr && !clr_pending) ? req_mask : '0;
    eff         = clr_pending ? '0 : (pending_q | incoming);
    state_d     = state_q;
    timer_d     = timer_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    arrive_d    = 1'b0;
    served      = '0;
    next_floor  = cur_floor_q;

    if (!hold) begin
      unique case (state_q)
        StIdle: begin
          if (|(eff & onehot(cur_floor_q))) begin
            state_d = StDoorOpen;
            timer_d = DoorLoad;
            served  = onehot(cur_floor_q);
          end else if (dir_up_q && any_above(eff, cur_floor_q)) begin
            state_d = StMoveUp;
            timer_d = TravelLoad;
          end else if (!dir_up_q && any_below(eff, cur_floor_q)) begin
            state_d = StMoveDown;
            timer_d = TravelLoad;
          end else if (any_above(eff, cur_floor_q)) begin
            state_d  = StMoveUp;
            timer_d  = TravelLoad;
            dir_up_d = 1'b1;
          end else if (any_below(eff, cur_floor_q)) begin
            state_d  = StMoveDown;
            timer_d  = TravelLoad;
            dir_up_d = 1'b0;
          end
        end
        StMoveUp, StMoveDown: begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else begin
            next_floor  = (state_q == StMoveUp) ? cur_floor_q + 1'b1 : cur_floor_q - 1'b1;
            cur_floor_d = next_floor;
            arrive_d    = 1'b1;
            if (|(eff & onehot(next_floor))) begin
              state_d = StDoorOpen;
              timer_d = DoorLoad;
              served  = onehot(next_floor);
            end else if ((state_q == StMoveUp) ? any_above(eff, next_floor)
                                               : any_below(eff, next_floor)) begin
              timer_d = TravelLoad;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StDoorOpen: begin
          // A request for the open floor extends the dwell rather than being latched
          served = onehot(cur_floor_q);
          if (|(incoming & onehot(cur_floor_q))) begin
            timer_d = DoorLoad;
          end else if (timer_q == '0) begin
            state_d = StIdle;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q == StDoorOpen) begin
      served = onehot(cur_floor_q);
    end

    pending_d = clr_pending ? '0 : ((pending_q | incoming) & ~served);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
      arrive_q    <= 1'b0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
      arrive_q    <= arrive_d;
      moving_q    <= (state_d == StMoveUp) || (state_d == StMoveDown);
      door_open_q <= (state_d == StDoorOpen);
      timer_q     <= timer_d;
    end
  end

  assign cur_floor = cur_floor_q;
  assign dir_up    = dir_up_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;
  assign pending   = pending_q;
  assign arrive    = arrive_q;
  assign state     = state_q;

  // The scheduler must never command travel past either end of the shaft
  a_no_overrun_top : assert property (@(posedge ACLK) disable iff (!ARESETN)
    (state_q != StMoveUp) || (cur_floor_q != TopFloor));
  a_no_overrun_bot : assert property (@(posedge ACLK) disable iff (!ARESETN)
    (state_q != StMoveDown) || (cur_floor_q != '0));

endmodule

// File: tb/tb_elevator_fsm_core.sv
// Directed bench for elevator_fsm_core: table of per-step vectors plus hand-written
// sequences for hold, asynchronous reset and clear-priority corner cases.
module tb_elevator_fsm_core;

  logic       ACLK;
  logic       ARESETN;
  logic       req_wr;
  logic [3:0] req_mask;
  logic       clr_pending;
  logic       hold;
  logic [1:0] cur_floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic [3:0] pending;
  logic       arrive;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  elevator_fsm_core #(
    .NUM_FLOORS   (4),
    .FLOOR_W      (2),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3),
    .CNT_W        (16)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .req_wr     (req_wr),
    .req_mask   (req_mask),
    .clr_pending(clr_pending),
    .hold       (hold),
    .cur_floor  (cur_floor),
    .dir_up     (dir_up),
    .moving     (moving),
    .door_open  (door_open),
    .pending    (pending),
    .arrive     (arrive),
    .state      (state)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic       wr;
    logic [3:0] mask;
    int         wait_n;   // extra idle cycles after the stimulus cycle
    logic [1:0] floor;
    logic [1:0] st;
    logic [3:0] pend;
    logic       dir;
    logic       arr;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic wr, input logic [3:0] mask, input int w,
                              input logic [1:0] fl, input logic [1:0] st,
                              input logic [3:0] pd, input logic dir, input logic arr);
    vec_t v;
    v.wr = wr; v.mask = mask; v.wait_n = w; v.floor = fl;
    v.st = st; v.pend = pd; v.dir = dir; v.arr = arr;
    return v;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Door and motion flags are fixed functions of the expected state code
  task automatic chk_all(input string tag, input logic [1:0] fl, input logic [1:0] st,
                         input logic [3:0] pd, input logic dir, input logic arr);
    chk({tag, ".floor"},   {6'd0, cur_floor}, {6'd0, fl});
    chk({tag, ".state"},   {6'd0, state},     {6'd0, st});
    chk({tag, ".pending"}, {4'd0, pending},   {4'd0, pd});
    chk({tag, ".dir_up"},  {7'd0, dir_up},    {7'd0, dir});
    chk({tag, ".arrive"},  {7'd0, arrive},    {7'd0, arr});
    chk({tag, ".door"},    {7'd0, door_open}, {7'd0, (st == 2'd3)});
    chk({tag, ".moving"},  {7'd0, moving},    {7'd0, (st == 2'd1) || (st == 2'd2)});
  endtask

  task automatic pulse_req(input logic [3:0] m);
    req_wr = 1'b1;
    req_mask = m;
    tick();
    req_wr = 1'b0;
    req_mask = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Upward sweep to floor 3, downward SCAN 3->2->0, door reload at floor 0
    vecs[0]  = mk(1'b1, 4'b1000, 0, 2'd0, 2'd1, 4'b1000, 1'b1, 1'b0);
    vecs[1]  = mk(1'b0, 4'b0000, 3, 2'd1, 2'd1, 4'b1000, 1'b1, 1'b1);
    vecs[2]  = mk(1'b0, 4'b0000, 0, 2'd1, 2'd1, 4'b1000, 1'b1, 1'b0);
    vecs[3]  = mk(1'b0, 4'b0000, 2, 2'd2, 2'd1, 4'b1000, 1'b1, 1'b1);
    vecs[4]  = mk(1'b0, 4'b0000, 3, 2'd3, 2'd3, 4'b0000, 1'b1, 1'b1);
    vecs[5]  = mk(1'b0, 4'b0000, 1, 2'd3, 2'd3, 4'b0000, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 4'b0000, 0, 2'd3, 2'd0, 4'b0000, 1'b1, 1'b0);
    vecs[7]  = mk(1'b1, 4'b0101, 0, 2'd3, 2'd2, 4'b0101, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 4'b0000, 3, 2'd2, 2'd3, 4'b0001, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 4'b0000, 2, 2'd2, 2'd0, 4'b0001, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 4'b0000, 0, 2'd2, 2'd2, 4'b0001, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 4'b0000, 3, 2'd1, 2'd2, 4'b0001, 1'b0, 1'b1);
    vecs[12] = mk(1'b0, 4'b0000, 3, 2'd0, 2'd3, 4'b0000, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 4'b0000, 2, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 4'b0001, 0, 2'd0, 2'd3, 4'b0000, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 4'b0000, 0, 2'd0, 2'd3, 4'b0000, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 4'b0001, 0, 2'd0, 2'd3, 4'b0000, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 4'b0000, 1, 2'd0, 2'd3, 4'b0000, 1'b0, 1'b0);
    vecs[18] = mk(1'b0, 4'b0000, 0, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0);

    ARESETN = 1'b0;
    req_wr = 1'b0;
    req_mask = 4'b0000;
    clr_pending = 1'b0;
    hold = 1'b0;
    #100;
    ARESETN = 1'b1;
    tick();
    chk_all("reset", 2'd0, 2'd0, 4'b0000, 1'b1, 1'b0);

    for (int i = 0; i < 19; i++) begin
      req_wr = vecs[i].wr;
      req_mask = vecs[i].mask;
      tick();
      req_wr = 1'b0;
      req_mask = 4'b0000;
      repeat (vecs[i].wait_n) tick();
      chk_all($sformatf("vec%0d", i), vecs[i].floor, vecs[i].st, vecs[i].pend,
              vecs[i].dir, vecs[i].arr);
    end

    // Hold mid-travel: floor 0 -> 2, hold one cycle after first arrive (timer at 2)
    pulse_req(4'b0100);
    chk_all("h_start", 2'd0, 2'd1, 4'b0100, 1'b1, 1'b0);
    repeat (4) tick();
    chk_all("h_arr1", 2'd1, 2'd1, 4'b0100, 1'b1, 1'b1);
    tick();
    hold = 1'b1;
    pulse_req(4'b1000);
    chk_all("h_wr", 2'd1, 2'd1, 4'b1100, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_all($sformatf("h_frz%0d", i), 2'd1, 2'd1, 4'b1100, 1'b1, 1'b0);
    end
    hold = 1'b0;
    repeat (2) tick();
    chk_all("h_rel", 2'd1, 2'd1, 4'b1100, 1'b1, 1'b0);
    tick();
    chk_all("h_arr2", 2'd2, 2'd3, 4'b1000, 1'b1, 1'b1);
    repeat (3) tick();
    chk_all("h_idle2", 2'd2, 2'd0, 4'b1000, 1'b1, 1'b0);
    tick();
    chk_all("h_go3", 2'd2, 2'd1, 4'b1000, 1'b1, 1'b0);
    repeat (4) tick();
    chk_all("h_arr3", 2'd3, 2'd3, 4'b0000, 1'b1, 1'b1);
    repeat (3) tick();
    chk_all("h_end", 2'd3, 2'd0, 4'b0000, 1'b1, 1'b0);

    // Asynchronous reset mid-travel, away from any clock edge
    pulse_req(4'b0001);
    chk_all("r_start", 2'd3, 2'd2, 4'b0001, 1'b0, 1'b0);
    repeat (5) tick();
    chk_all("r_mid", 2'd2, 2'd2, 4'b0001, 1'b0, 1'b0);
    #2;
    ARESETN = 1'b0;
    #1;
    chk_all("r_async", 2'd0, 2'd0, 4'b0000, 1'b1, 1'b0);
    #1;
    ARESETN = 1'b1;
    repeat (3) tick();
    chk_all("r_after", 2'd0, 2'd0, 4'b0000, 1'b1, 1'b0);

    // clr_pending beats a simultaneous req_wr (hold keeps the scheduler out of it)
    hold = 1'b1;
    pulse_req(4'b0100);
    chk_all("c_set", 2'd0, 2'd0, 4'b0100, 1'b1, 1'b0);
    clr_pending = 1'b1;
    pulse_req(4'b0010);
    clr_pending = 1'b0;
    chk_all("c_clr", 2'd0, 2'd0, 4'b0000, 1'b1, 1'b0);
    hold = 1'b0;
    tick();
    chk_all("c_idle", 2'd0, 2'd0, 4'b0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
